// File: rtl/gpu_pkg.sv
// Shared core sequencer definitions.
// The state encoding is also decoded by the pc, fetcher and LSU blocks, so the
// values below must not change.
package gpu_pkg;

   typedef enum logic [2:0] {
      CORE_IDLE    = 3'b000,
      CORE_FETCH   = 3'b001,
      CORE_DECODE  = 3'b010,
      CORE_REQUEST = 3'b011,
      CORE_WAIT    = 3'b100,
      CORE_EXECUTE = 3'b101,
      CORE_UPDATE  = 3'b110,
      CORE_DONE    = 3'b111
   } core_state_t;

endpackage

// File: rtl/pc_min_select.sv
// Minimum-PC selector for divergent warps (purely combinational).
// Ports:
//   cand  - packed per-lane candidate PCs, lane i at [i*AW +: AW]
//   live  - lanes that take part in the selection
//   sel   - smallest candidate PC among live lanes (0 when no lane is live)
//   match - live lanes whose candidate equals sel
module pc_min_select #(
   parameter int unsigned LANES = 4,
   parameter int unsigned AW    = 8
) (
   input  logic [LANES*AW-1:0] cand,
   input  logic [LANES-1:0]    live,
   output logic [AW-1:0]       sel,
   output logic [LANES-1:0]    match
);

   logic found;

   // Linear unsigned min-reduction over the live lanes.
   always_comb begin
      sel   = '0;
      found = 1'b0;
      for (int i = 0; i < int'(LANES); i++) begin
         if (live[i] && (!found || (cand[i*AW +: AW] < sel))) begin
            sel   = cand[i*AW +: AW];
            found = 1'b1;
         end
      end
   end

   // Lanes sitting at the minimum PC are issued together; equal PCs reconverge.
   always_comb begin
      match = '0;
      for (int i = 0; i < int'(LANES); i++) begin
         match[i] = live[i] && (cand[i*AW +: AW] == sel);
      end
   end

endmodule

// File: rtl/warp_scheduler.sv
// Per-core instruction sequencer with branch-divergence handling.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   start         - launch the block while idle
//   thread_count  - number of enabled threads (clamped to THREADS_PER_BLOCK)
//   fetch_done    - instruction for current_pc delivered
//   lsu_waiting   - per-lane outstanding memory request
//   decoded_ret   - current instruction is RET
//   next_pc       - packed per-lane next PC, valid during UPDATE
//   core_state    - sequencer state, decoded by the per-lane units
//   current_pc    - PC being issued
//   thread_mask   - lanes executing the current instruction
//   done          - every thread has retired
module warp_scheduler
   import gpu_pkg::*;
#(
   parameter int THREADS_PER_BLOCK     = 4,
   parameter int PROGRAM_MEM_ADDR_BITS = 8
) (
   input  logic                                             clk,
   input  logic                                             reset,
   input  logic                                             start,
   input  logic [$clog2(THREADS_PER_BLOCK):0]               thread_count,
   input  logic                                             fetch_done,
   input  logic [THREADS_PER_BLOCK-1:0]                     lsu_waiting,
   input  logic                                             decoded_ret,
   input  logic [THREADS_PER_BLOCK*PROGRAM_MEM_ADDR_BITS-1:0] next_pc,
   output logic [2:0]                                       core_state,
   output logic [PROGRAM_MEM_ADDR_BITS-1:0]                 current_pc,
   output logic [THREADS_PER_BLOCK-1:0]                     thread_mask,
   output logic                                             done
);

   localparam int unsigned T   = THREADS_PER_BLOCK;
   localparam int unsigned AW  = PROGRAM_MEM_ADDR_BITS;
   localparam int unsigned TCW = $clog2(THREADS_PER_BLOCK) + 1;

   core_state_t     state_q, state_d;
   logic [T-1:0]    live_q, live_d;
   logic [T*AW-1:0] parked_q, parked_d;
   logic [AW-1:0]   pc_q, pc_d;
   logic [T-1:0]    mask_q, mask_d;
   logic            done_q, done_d;

   logic [TCW-1:0]  n_c;
   logic [T-1:0]    start_mask_c;
   logic            stall_c;
   logic [T*AW-1:0] cand_c;
   logic [T-1:0]    live_next_c;
   logic [AW-1:0]   sel_c;
   logic [T-1:0]    match_c;

   // Launch mask: lanes [n-1:0] with n clamped to the lane count.
   always_comb begin
      n_c = (thread_count > TCW'(T)) ? TCW'(T) : thread_count;
      start_mask_c = '0;
      for (int i = 0; i < int'(T); i++) begin
         start_mask_c[i] = TCW'(i) < n_c;
      end
   end

   // Only issued lanes can hold the warp in WAIT.
   assign stall_c = |(lsu_waiting & mask_q);

   // Issued lanes advance to their computed PC; parked lanes keep theirs.
   always_comb begin
      for (int i = 0; i < int'(T); i++) begin
         cand_c[i*AW +: AW] = mask_q[i] ? next_pc[i*AW +: AW] : parked_q[i*AW +: AW];
      end
   end

   assign live_next_c = live_q & ~(decoded_ret ? mask_q : '0);

   pc_min_select #(
      .LANES (T),
      .AW    (AW)
   ) u_min_sel (
      .cand  (cand_c),
      .live  (live_next_c),
      .sel   (sel_c),
      .match (match_c)
   );

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= CORE_IDLE;
         live_q   <= '0;
         parked_q <= '0;
         pc_q     <= '0;
         mask_q   <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         live_q   <= live_d;
         parked_q <= parked_d;
         pc_q     <= pc_d;
         mask_q   <= mask_d;
         done_q   <= done_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         CORE_IDLE:    if (start) state_d = (n_c == '0) ? CORE_DONE : CORE_FETCH;
         CORE_FETCH:   if (fetch_done) state_d = CORE_DECODE;
         CORE_DECODE:  state_d = CORE_REQUEST;
         CORE_REQUEST: state_d = CORE_WAIT;
         CORE_WAIT:    if (!stall_c) state_d = CORE_EXECUTE;
         CORE_EXECUTE: state_d = CORE_UPDATE;
         CORE_UPDATE:  state_d = (live_next_c == '0) ? CORE_DONE : CORE_FETCH;
         CORE_DONE:    state_d = CORE_DONE;
         default:      state_d = CORE_IDLE;
      endcase
   end

   // Datapath register updates on launch and at the end of each instruction.
   always_comb begin
      live_d   = live_q;
      parked_d = parked_q;
      pc_d     = pc_q;
      mask_d   = mask_q;
      done_d   = done_q;
      case (state_q)
         CORE_IDLE: begin
            if (start) begin
               if (n_c == '0) begin
                  done_d = 1'b1;
               end else begin
                  live_d   = start_mask_c;
                  mask_d   = start_mask_c;
                  pc_d     = '0;
                  parked_d = '0;
               end
            end
         end
         CORE_UPDATE: begin
            parked_d = cand_c;
            live_d   = live_next_c;
            if (live_next_c == '0) begin
               done_d = 1'b1;
               mask_d = '0;
            end else begin
               pc_d   = sel_c;
               mask_d = match_c;
            end
         end
         default: ;
      endcase
   end

   assign core_state  = state_q;
   assign current_pc  = pc_q;
   assign thread_mask = mask_q;
   assign done        = done_q;

endmodule

// File: tb/tb_warp_scheduler.sv
// Directed bench for warp_scheduler: a small program model answers the
// scheduler's PC with per-lane next PCs and RET flags.
module tb_warp_scheduler;
   import gpu_pkg::*;

   localparam int T  = 4;
   localparam int AW = 8;

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic [2:0]      thread_count;
   logic            fetch_done;
   logic [T-1:0]    lsu_waiting;
   logic            decoded_ret;
   logic [T*AW-1:0] next_pc;
   logic [2:0]      core_state;
   logic [AW-1:0]   current_pc;
   logic [T-1:0]    thread_mask;
   logic            done;

   int n_checks = 0;
   int n_errors = 0;
   int prog     = 0;

   warp_scheduler #(
      .THREADS_PER_BLOCK     (T),
      .PROGRAM_MEM_ADDR_BITS (AW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .thread_count (thread_count),
      .fetch_done   (fetch_done),
      .lsu_waiting  (lsu_waiting),
      .decoded_ret  (decoded_ret),
      .next_pc      (next_pc),
      .core_state   (core_state),
      .current_pc   (current_pc),
      .thread_mask  (thread_mask),
      .done         (done)
   );

   always #5 clk = ~clk;

   // Program model: 0 straight line with RET at 2; 1 diverge at 3, merge at 8,
   // RET at 8; 2 lanes 0,1 go to 1 (RET), lanes 2,3 go to 5 (RET).
   always_comb begin
      next_pc     = '0;
      decoded_ret = 1'b0;
      for (int i = 0; i < T; i++) next_pc[i*AW +: AW] = 8'(current_pc + 8'd1);
      case (prog)
         0: decoded_ret = (current_pc == 8'd2);
         1: begin
            if (current_pc == 8'd3) begin
               next_pc[0*AW +: AW] = 8'd8;
               next_pc[1*AW +: AW] = 8'd8;
               next_pc[2*AW +: AW] = 8'd4;
               next_pc[3*AW +: AW] = 8'd4;
            end
            decoded_ret = (current_pc == 8'd8);
         end
         2: begin
            if (current_pc == 8'd0) begin
               next_pc[0*AW +: AW] = 8'd1;
               next_pc[1*AW +: AW] = 8'd1;
               next_pc[2*AW +: AW] = 8'd5;
               next_pc[3*AW +: AW] = 8'd5;
            end
            decoded_ret = (current_pc == 8'd1) || (current_pc == 8'd5);
         end
         default: ;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic wait_state(input logic [2:0] st, input string tag);
      logic found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         if (core_state == st) found = 1'b1;
         else step();
      end
      check(tag, 32'(found), 32'd1);
   endtask

   task automatic wait_fetch_pc(input logic [AW-1:0] pc, input string tag);
      logic found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         if (core_state == CORE_FETCH && current_pc == pc) found = 1'b1;
         else step();
      end
      check(tag, 32'(found), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_state"}, 32'(core_state), 32'(CORE_IDLE));
      check({tag, "_pc"}, 32'(current_pc), 32'd0);
      check({tag, "_mask"}, 32'(thread_mask), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
   endtask

   initial begin
      logic [AW-1:0] fetch_pcs [4];
      int            nfetch;
      logic          mask_bad;

      reset        = 1'b1;
      start        = 1'b0;
      thread_count = 3'd4;
      fetch_done   = 1'b1;
      lsu_waiting  = '0;
      step();
      step();
      reset = 1'b0;
      check_reset_outputs("por");

      // Straight line, 4 threads: fetches at 0,1,2 then DONE 18 cycles later.
      prog  = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      check("sl_first_state", 32'(core_state), 32'(CORE_FETCH));
      check("sl_first_pc", 32'(current_pc), 32'd0);
      check("sl_first_mask", 32'(thread_mask), 32'hF);
      nfetch       = 1;
      fetch_pcs[0] = current_pc;
      mask_bad     = 1'b0;
      for (int i = 1; i <= 18; i++) begin
         step();
         if (core_state == CORE_FETCH && nfetch < 4) begin
            fetch_pcs[nfetch] = current_pc;
            nfetch++;
         end
         if (core_state != CORE_DONE && thread_mask != 4'hF) mask_bad = 1'b1;
         if (i == 17) check("sl_pre_done", 32'(done), 32'd0);
      end
      check("sl_fetch_count", 32'(nfetch), 32'd3);
      check("sl_fetch_pc1", 32'(fetch_pcs[1]), 32'd1);
      check("sl_fetch_pc2", 32'(fetch_pcs[2]), 32'd2);
      check("sl_mask_steady", 32'(mask_bad), 32'd0);
      check("sl_done_state", 32'(core_state), 32'(CORE_DONE));
      check("sl_done", 32'(done), 32'd1);
      check("sl_done_mask", 32'(thread_mask), 32'd0);
      start = 1'b1;
      step();
      step();
      start = 1'b0;
      check("done_hold_state", 32'(core_state), 32'(CORE_DONE));
      check("done_hold_done", 32'(done), 32'd1);

      // Divergence at pc 3, reconvergence at pc 8.
      apply_reset();
      prog  = 1;
      start = 1'b1;
      step();
      start = 1'b0;
      wait_fetch_pc(8'd4, "div_reach_4");
      check("div_mask_4", 32'(thread_mask), 32'hC);
      wait_fetch_pc(8'd7, "div_reach_7");
      check("div_mask_7", 32'(thread_mask), 32'hC);
      wait_fetch_pc(8'd8, "div_reach_8");
      check("div_mask_8", 32'(thread_mask), 32'hF);
      wait_state(CORE_DONE, "div_reach_done");
      check("div_done", 32'(done), 32'd1);

      // Partial RET: lanes 0,1 retire at pc 1, parked lanes 2,3 resume at pc 5.
      apply_reset();
      prog  = 2;
      start = 1'b1;
      step();
      start = 1'b0;
      wait_fetch_pc(8'd1, "pret_reach_1");
      check("pret_mask_1", 32'(thread_mask), 32'h3);
      wait_fetch_pc(8'd5, "pret_reach_5");
      check("pret_mask_5", 32'(thread_mask), 32'hC);
      check("pret_not_done", 32'(done), 32'd0);
      wait_state(CORE_DONE, "pret_reach_done");
      check("pret_done", 32'(done), 32'd1);

      // thread_count=2 with LSU busy only on inactive lanes: no stall.
      apply_reset();
      prog         = 0;
      thread_count = 3'd2;
      lsu_waiting  = 4'b1100;
      start        = 1'b1;
      step();
      start = 1'b0;
      check("tc2_mask", 32'(thread_mask), 32'h3);
      for (int i = 1; i <= 18; i++) step();
      check("tc2_no_stall", 32'(core_state), 32'(CORE_DONE));
      lsu_waiting = '0;

      // thread_count=7 clamps; start pulsed during FETCH is ignored.
      apply_reset();
      thread_count = 3'd7;
      fetch_done   = 1'b0;
      start        = 1'b1;
      step();
      start = 1'b0;
      check("tc7_mask", 32'(thread_mask), 32'hF);
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      check("fetch_hold_state", 32'(core_state), 32'(CORE_FETCH));
      check("fetch_hold_pc", 32'(current_pc), 32'd0);
      check("fetch_hold_mask", 32'(thread_mask), 32'hF);
      fetch_done = 1'b1;
      step();
      check("fetch_release", 32'(core_state), 32'(CORE_DECODE));

      // thread_count=0 goes straight to DONE.
      apply_reset();
      thread_count = 3'd0;
      start        = 1'b1;
      step();
      start = 1'b0;
      check("tc0_state", 32'(core_state), 32'(CORE_DONE));
      check("tc0_done", 32'(done), 32'd1);
      check("tc0_mask", 32'(thread_mask), 32'd0);

      // WAIT stall: active lane 1 busy for 5 WAIT cycles.
      apply_reset();
      thread_count = 3'd4;
      start        = 1'b1;
      step();
      start       = 1'b0;
      lsu_waiting = 4'b0010;
      step();
      step();
      step();
      check("stall_enter", 32'(core_state), 32'(CORE_WAIT));
      for (int k = 2; k <= 5; k++) begin
         step();
         check("stall_hold", 32'(core_state), 32'(CORE_WAIT));
      end
      lsu_waiting = '0;
      step();
      check("stall_release", 32'(core_state), 32'(CORE_EXECUTE));

      // Reset in WAIT of the next instruction (pc 1).
      lsu_waiting = 4'b0010;
      wait_fetch_pc(8'd1, "rst_wait_pc1");
      wait_state(CORE_WAIT, "rst_wait_reach");
      reset = 1'b1;
      step();
      check_reset_outputs("rst_wait");
      reset       = 1'b0;
      lsu_waiting = '0;

      // Reset in UPDATE while diverged.
      prog  = 1;
      start = 1'b1;
      step();
      start = 1'b0;
      wait_fetch_pc(8'd4, "rst_upd_pc4");
      wait_state(CORE_UPDATE, "rst_upd_reach");
      reset = 1'b1;
      step();
      check_reset_outputs("rst_upd");
      reset = 1'b0;

      // Relaunch after reset: no residue from the diverged warp.
      prog  = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      check("relaunch_pc", 32'(current_pc), 32'd0);
      check("relaunch_mask", 32'(thread_mask), 32'hF);
      wait_state(CORE_DONE, "relaunch_done_reach");
      check("relaunch_done", 32'(done), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
